block_sparse_pruner: RTL and testbench

Streaming weight pre-conditioner placed directly upstream of the block-sparse linear stage on its weight port. Per weight beat, for each of PARALLELISM output rows, it computes the L1 magnitude of every BLOCK_SIZE-element block. It keeps the KEEP = WEIGHT_BLOCKS − WEIGHT_BLOCKS_SPARSE largest blocks and forces all other blocks to zero. This guarantees the sparsity pattern that the downstream non-zero-block mux depends on. The block is a two-stage valid/ready pipeline with full throughput and a saturating prune counter.

---
 rtl/sparse_pkg.sv | 12 +
 rtl/block_topk_mask.sv | 49 ++++
 rtl/block_sparse_pruner.sv | 107 ++++++++++
 tb/tb_block_sparse_pruner.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared sizing helpers for the block-sparse weight path (pruner and linear stage).
package sparse_pkg;

   function automatic int NORM_W(input int weight_width, input int block_size);
      return weight_width + $clog2(block_size);
   endfunction

   function automatic int KEEP_BLOCKS(input int weight_blocks, input int weight_blocks_sparse);
      return weight_blocks - weight_blocks_sparse;
   endfunction

endpackage

// File: rtl/block_topk_mask.sv
// One row: per-block L1 norms, rank against the other blocks, keep mask for the top KEEP.
module block_topk_mask
   import sparse_pkg::*;
#(
   parameter int BLOCK_SIZE           = 4,
   parameter int WEIGHT_BLOCKS        = 3,
   parameter int WEIGHT_BLOCKS_SPARSE = 2,
   parameter int WEIGHT_WIDTH         = 16
) (
   input  logic [BLOCK_SIZE*WEIGHT_BLOCKS-1:0][WEIGHT_WIDTH-1:0] row_i,
   output logic [WEIGHT_BLOCKS-1:0]                              keep_o,
   output logic                                                  pruned_o
);

   localparam int NW   = NORM_W(WEIGHT_WIDTH, BLOCK_SIZE);
   localparam int KEEP = KEEP_BLOCKS(WEIGHT_BLOCKS, WEIGHT_BLOCKS_SPARSE);
   localparam int RW   = $clog2(WEIGHT_BLOCKS + 1);

   // Unsigned magnitude in the same width: -2^(W-1) wraps to exactly 2^(W-1).
   function automatic logic [WEIGHT_WIDTH-1:0] mag(input logic [WEIGHT_WIDTH-1:0] w);
      return w[WEIGHT_WIDTH-1] ? (~w) + WEIGHT_WIDTH'(1) : w;
   endfunction

   logic [WEIGHT_BLOCKS-1:0][NW-1:0] norm;
   logic [WEIGHT_BLOCKS-1:0][RW-1:0] beaten;
   logic [WEIGHT_BLOCKS-1:0]         nz;

   always_comb begin
      norm   = '0;
      beaten = '0;
      nz     = '0;
      keep_o = '0;
      for (int j = 0; j < WEIGHT_BLOCKS; j++) begin
         for (int k = 0; k < BLOCK_SIZE; k++)
            norm[j] = norm[j] + NW'(mag(row_i[j*BLOCK_SIZE+k]));
         nz[j] = |norm[j];
      end
      // Ties go to the lower block index, so exactly KEEP blocks survive.
      for (int j = 0; j < WEIGHT_BLOCKS; j++) begin
         for (int k = 0; k < WEIGHT_BLOCKS; k++) begin
            if (k != j && (norm[k] > norm[j] || (norm[k] == norm[j] && k < j)))
               beaten[j] = beaten[j] + RW'(1);
         end
         keep_o[j] = (beaten[j] < RW'(KEEP));
      end
      pruned_o = |(~keep_o & nz);
   end

endmodule

// File: rtl/block_sparse_pruner.sv
// Two-stage valid/ready pipeline enforcing top-KEEP block sparsity per row, with a prune counter.
module block_sparse_pruner
   import sparse_pkg::*;
#(
   parameter int BLOCK_SIZE           = 4,
   parameter int WEIGHT_BLOCKS        = 3,
   parameter int WEIGHT_BLOCKS_SPARSE = 2,
   parameter int WEIGHT_WIDTH         = 16,
   parameter int PARALLELISM          = 2,
   parameter int WEIGHT_SIZE          = BLOCK_SIZE*WEIGHT_BLOCKS*PARALLELISM,
   parameter int CNT_WIDTH            = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0]  weight_in,
   input  logic                                      weight_in_valid,
   output logic                                      weight_in_ready,
   output logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0]  weight_out,
   output logic                                      weight_out_valid,
   input  logic                                      weight_out_ready,
   input  logic                                      count_clear,
   output logic [CNT_WIDTH-1:0]                      prune_count
);

   localparam int ROW_E = BLOCK_SIZE*WEIGHT_BLOCKS;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [PARALLELISM-1:0][WEIGHT_BLOCKS-1:0]   keep_d, s1_keep_q;
   logic [PARALLELISM-1:0]                      row_pruned;
   logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0]    s1_data_q, s2_data_q, masked_d;
   logic                                        s1_v_q, s2_v_q, s1_flag_q, s2_flag_q;
   logic                                        s1_adv, s2_adv;
   logic [CNT_WIDTH-1:0]                        cnt_q, cnt_d;

   for (genvar r = 0; r < PARALLELISM; r++) begin : g_row
      block_topk_mask #(
         .BLOCK_SIZE           (BLOCK_SIZE),
         .WEIGHT_BLOCKS        (WEIGHT_BLOCKS),
         .WEIGHT_BLOCKS_SPARSE (WEIGHT_BLOCKS_SPARSE),
         .WEIGHT_WIDTH         (WEIGHT_WIDTH)
      ) u_mask (
         .row_i    (weight_in[r*ROW_E +: ROW_E]),
         .keep_o   (keep_d[r]),
         .pruned_o (row_pruned[r])
      );
   end

   assign s2_adv          = !s2_v_q | weight_out_ready;
   assign s1_adv          = !s1_v_q | s2_adv;
   assign weight_in_ready = s1_adv;

   always_comb begin
      masked_d = '0;
      for (int r = 0; r < PARALLELISM; r++)
         for (int j = 0; j < WEIGHT_BLOCKS; j++)
            for (int k = 0; k < BLOCK_SIZE; k++)
               masked_d[r*ROW_E+j*BLOCK_SIZE+k] =
                  s1_keep_q[r][j] ? s1_data_q[r*ROW_E+j*BLOCK_SIZE+k] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         s1_keep_q <= '0;
         s1_flag_q <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_flag_q <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_v_q <= weight_in_valid;
            if (weight_in_valid) begin
               s1_data_q <= weight_in;
               s1_keep_q <= keep_d;
               s1_flag_q <= |row_pruned;
            end
         end
         if (s2_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
               s2_data_q <= masked_d;
               s2_flag_q <= s1_flag_q;
            end
         end
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (count_clear)
         cnt_d = '0;
      else if (s2_v_q && weight_out_ready && s2_flag_q && cnt_q != CNT_MAX)
         cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign weight_out       = s2_data_q;
   assign weight_out_valid = s2_v_q;
   assign prune_count      = cnt_q;

endmodule

// File: tb/tb_block_sparse_pruner.sv
// Scoreboard bench: driver pushes reference-model results, negedge monitor pops and compares.
module tb_block_sparse_pruner;

   localparam int BS = 4, WB = 3, WBS = 2, WW = 16, P = 2, CW = 16;
   localparam int WS = BS*WB*P, ROWE = BS*WB, KEEP = WB - WBS;

   typedef logic [WS-1:0][WW-1:0] beat_t;
   typedef struct { beat_t data; bit flag; } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   beat_t         weight_in = '0;
   logic          weight_in_valid = 1'b0;
   logic          weight_in_ready;
   beat_t         weight_out;
   logic          weight_out_valid;
   logic          weight_out_ready = 1'b0;
   logic          count_clear = 1'b0;
   logic [CW-1:0] prune_count;

   always #5 clk = ~clk;

   block_sparse_pruner dut (
      .clk              (clk),
      .rst              (rst),
      .weight_in        (weight_in),
      .weight_in_valid  (weight_in_valid),
      .weight_in_ready  (weight_in_ready),
      .weight_out       (weight_out),
      .weight_out_valid (weight_out_valid),
      .weight_out_ready (weight_out_ready),
      .count_clear      (count_clear),
      .prune_count      (prune_count)
   );

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   bit   rand_rdy = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Reference: pick the KEEP largest norms one at a time, earliest index winning ties.
   function automatic exp_t model(input beat_t b);
      exp_t e;
      int   norm[WB];
      bit   kept[WB];
      e.data = b;
      e.flag = 0;
      for (int r = 0; r < P; r++) begin
         for (int j = 0; j < WB; j++) begin
            norm[j] = 0;
            kept[j] = 0;
            for (int k = 0; k < BS; k++) begin
               int v;
               v = $signed(b[r*ROWE+j*BS+k]);
               norm[j] += (v < 0) ? -v : v;
            end
         end
         for (int n = 0; n < KEEP; n++) begin
            int best;
            best = -1;
            for (int j = 0; j < WB; j++)
               if (!kept[j] && (best < 0 || norm[j] > norm[best])) best = j;
            kept[best] = 1;
         end
         for (int j = 0; j < WB; j++) begin
            if (!kept[j]) begin
               if (norm[j] != 0) e.flag = 1;
               for (int k = 0; k < BS; k++) e.data[r*ROWE+j*BS+k] = '0;
            end
         end
      end
      return e;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      for (int blk = 0; blk < P*WB; blk++) begin
         int mode;
         mode = int'($urandom_range(0, 4));
         for (int k = 0; k < BS; k++) begin
            int v;
            case (mode)
               0: v = 0;
               1: v = int'($urandom_range(0, 6)) - 3;
               2: v = int'($urandom);
               3: v = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
               default: v = 1;
            endcase
            b[blk*BS+k] = WW'(v);
         end
      end
      return b;
   endfunction

   task automatic send(input beat_t b);
      int n;
      bit rdy;
      n = 0;
      rdy = 0;
      weight_in = b;
      weight_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         rdy = weight_in_ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout act=stalled exp=accepted");
            break;
         end
      end
      if (rdy) sb.push_back(model(b));
      #1 weight_in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout act=%0d exp=0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pop on every output handshake, counter model, hold stability.
   initial begin
      beat_t held;
      bit    held_v;
      bit    hs, flag;
      exp_t  e;
      held_v = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_cnt = 0;
            held_v = 0;
         end else begin
            chk("prune_count", 64'(prune_count), 64'(exp_cnt));
            if (held_v) begin
               chk("hold_valid", 64'(weight_out_valid), 64'd1);
               checks++;
               if (weight_out !== held) begin
                  errors++;
                  $display("FAIL hold_data act=%h exp=%h", weight_out, held);
               end
            end
            held_v = weight_out_valid && !weight_out_ready;
            held = weight_out;
            hs = weight_out_valid && weight_out_ready;
            flag = 0;
            if (hs) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_out act=%h exp=none", weight_out);
               end else begin
                  e = sb.pop_front();
                  flag = e.flag;
                  if (weight_out !== e.data) begin
                     errors++;
                     $display("FAIL out_data act=%h exp=%h", weight_out, e.data);
                  end
               end
            end
            if (count_clear) exp_cnt = 0;
            else if (hs && flag && exp_cnt < 65535) exp_cnt++;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) weight_out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b1, bt, bsp, bx, e1, b;
      int    acc;
      bit    rdy;

      // Reset state
      #2;
      chk("rst_out_valid", 64'(weight_out_valid), 64'd0);
      chk("rst_count", 64'(prune_count), 64'd0);
      checks++;
      if (weight_out !== '0) begin
         errors++;
         $display("FAIL rst_out_data act=%h exp=0", weight_out);
      end
      #20 rst = 1'b1;
      #1 chk("rst_in_ready", 64'(weight_in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Norms 4,5,3: only block1 of row0 survives; latency and counter step
      b1 = '0;
      for (int k = 0; k < 4; k++) b1[k] = 16'd1;
      b1[4] = 16'd5;
      b1[9] = 16'hFFFD;
      e1 = '0;
      e1[4] = 16'd5;
      weight_out_ready = 1'b1;
      send(b1);
      chk("lat_s1", 64'(weight_out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_s2", 64'(weight_out_valid), 64'd1);
      checks++;
      if (weight_out !== e1) begin
         errors++;
         $display("FAIL dir_out act=%h exp=%h", weight_out, e1);
      end
      @(posedge clk);
      #1;
      chk("dir_count", 64'(prune_count), 64'd1);

      // Already sparse: passes through, count unchanged
      bsp = '0;
      bsp[8] = 16'd7;
      bsp[10] = 16'hFF00;
      bsp[20] = 16'd3;
      send(bsp);
      drain();
      chk("sparse_count", 64'(prune_count), 64'd1);

      // Tie: block0 wins
      bt = '0;
      for (int k = 0; k < 12; k++) bt[k] = 16'd1;
      send(bt);
      // Extreme: -32768 block outranks two norm-100 blocks
      bx = '0;
      bx[0] = 16'd100;
      bx[6] = 16'hFF9C;
      bx[8] = 16'h8000;
      send(bx);
      drain();
      chk("tie_ext_count", 64'(prune_count), 64'd3);

      // Random traffic with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         send(rand_beat());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy = 0;
      #1 weight_out_ready = 1'b1;
      drain();

      // Stalled output: exactly two beats fit
      weight_out_ready = 1'b0;
      weight_in_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         b = rand_beat();
         b[12] = WW'(i);
         weight_in = b;
         @(negedge clk);
         rdy = weight_in_ready;
         @(posedge clk);
         if (rdy) begin
            acc++;
            sb.push_back(model(b));
         end
         #1;
      end
      chk("bp_accepted", 64'(acc), 64'd2);
      chk("bp_in_ready", 64'(weight_in_ready), 64'd0);
      weight_in_valid = 1'b0;
      weight_out_ready = 1'b1;
      drain();

      // Asynchronous reset with both stages full
      weight_out_ready = 1'b0;
      send(b1);
      send(bt);
      #3 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(weight_out_valid), 64'd0);
      chk("arst_count", 64'(prune_count), 64'd0);
      sb.delete();
      #3 rst = 1'b1;
      weight_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_idle", 64'(weight_out_valid), 64'd0);
      end
      send(bsp);
      drain();

      // Saturation
      for (int i = 0; i < 65540; i++) send(b1);
      drain();
      chk("sat_count", 64'(prune_count), 64'hFFFF);

      // Clear coinciding with a flagged output handshake
      for (int i = 0; i < 10; i++) begin
         count_clear = (i == 5);
         send(b1);
         if (i == 5) begin
            chk("clear_prio", 64'(prune_count), 64'd0);
            count_clear = 1'b0;
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
